// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle-CPU memory access sequencer.
// Covers the FSM states, address-mux selects, exception causes and grant bit positions.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned GNT_W   = 3;

    localparam logic [SEL_W-1:0] SEL_PC     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_ALUOUT = 3'b001;
    localparam logic [SEL_W-1:0] SEL_V255   = 3'b010;
    localparam logic [SEL_W-1:0] SEL_V254   = 3'b011;
    localparam logic [SEL_W-1:0] SEL_V253   = 3'b100;
    localparam logic [SEL_W-1:0] SEL_RD     = 3'b101;

    localparam logic [CAUSE_W-1:0] CAUSE_INV_OP = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_OVF    = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_DIV0   = 2'b10;
    localparam logic [CAUSE_W-1:0] CAUSE_RSVD   = 2'b11;

    // One-hot grant bit positions
    localparam int unsigned GNT_FETCH = 0;
    localparam int unsigned GNT_DATA  = 1;
    localparam int unsigned GNT_EXC   = 2;

    // Address-mux select for a latched winner; invalid-opcode and reserved share vector 253
    function automatic logic [SEL_W-1:0] addr_sel(
        input logic [GNT_W-1:0]   win,
        input logic               src,
        input logic [CAUSE_W-1:0] cause
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_PC;
        if (win[GNT_EXC]) begin
            case (cause)
                CAUSE_OVF:  sel = SEL_V254;
                CAUSE_DIV0: sel = SEL_V255;
                default:    sel = SEL_V253;
            endcase
        end else if (win[GNT_DATA]) begin
            sel = src ? SEL_RD : SEL_ALUOUT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Fixed-priority arbiter for the single memory port: exception > data > fetch.
module mem_req_arbiter
    import cpu_ctrl_pkg::*;
(
    input  logic             fetch_req,
    input  logic             data_req,
    input  logic             exc_req,
    output logic [GNT_W-1:0] gnt_c
);

    always_comb begin
        gnt_c = '0;
        if (exc_req) begin
            gnt_c[GNT_EXC] = 1'b1;
        end else if (data_req) begin
            gnt_c[GNT_DATA] = 1'b1;
        end else if (fetch_req) begin
            gnt_c[GNT_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory-port controller: arbitrates fetch/data/exception-vector accesses and sequences
// each through address setup, MEM_LATENCY wait cycles and a completion cycle.
module mem_access_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic               data_src,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    output logic [SEL_W-1:0]   mux_sel,
    output logic               mem_wr,
    output logic               ir_load,
    output logic               mdr_load,
    output logic               exc_load,
    output logic               fetch_done,
    output logic               data_done,
    output logic               exc_done,
    output logic               busy
);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GNT_W-1:0]   win_q, win_d;
    logic               wr_q, wr_d;
    logic               src_q, src_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
    logic               mem_wr_q, mem_wr_d;
    logic               ir_load_q, ir_load_d;
    logic               mdr_load_q, mdr_load_d;
    logic               exc_load_q, exc_load_d;
    logic               fetch_done_q, fetch_done_d;
    logic               data_done_q, data_done_d;
    logic               exc_done_q, exc_done_d;
    logic               busy_q, busy_d;

    logic [GNT_W-1:0]   gnt_c;
    logic               enter_done_c;

    mem_req_arbiter u_arb (
        .fetch_req (fetch_req),
        .data_req  (data_req),
        .exc_req   (exc_req),
        .gnt_c     (gnt_c)
    );

    // Next state, latched request fields and registered-output decode of the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        wr_d     = wr_q;
        src_d    = src_q;
        cause_d  = cause_q;
        mem_wr_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    win_d    = gnt_c;
                    wr_d     = data_wr;
                    src_d    = data_src;
                    cause_d  = exc_cause;
                    mem_wr_d = gnt_c[GNT_DATA] & data_wr;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = (MEM_LATENCY == 0) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Select derives only from latched fields, so it cannot move between ADDR and DONE
        mux_sel_d = (state_d == IDLE) ? SEL_PC : addr_sel(win_d, src_d, cause_d);
        busy_d    = (state_d != IDLE);

        enter_done_c = (state_d == DONE);
        fetch_done_d = enter_done_c & win_d[GNT_FETCH];
        data_done_d  = enter_done_c & win_d[GNT_DATA];
        exc_done_d   = enter_done_c & win_d[GNT_EXC];
        ir_load_d    = enter_done_c & win_d[GNT_FETCH];
        mdr_load_d   = enter_done_c & win_d[GNT_DATA] & ~wr_d;
        exc_load_d   = enter_done_c & win_d[GNT_EXC];
    end

    // State, latched fields and output registers; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_q        <= '0;
            wr_q         <= 1'b0;
            src_q        <= 1'b0;
            cause_q      <= '0;
            mux_sel_q    <= SEL_PC;
            mem_wr_q     <= 1'b0;
            ir_load_q    <= 1'b0;
            mdr_load_q   <= 1'b0;
            exc_load_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            exc_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            wr_q         <= wr_d;
            src_q        <= src_d;
            cause_q      <= cause_d;
            mux_sel_q    <= mux_sel_d;
            mem_wr_q     <= mem_wr_d;
            ir_load_q    <= ir_load_d;
            mdr_load_q   <= mdr_load_d;
            exc_load_q   <= exc_load_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
            exc_done_q   <= exc_done_d;
            busy_q       <= busy_d;
        end
    end

    assign mux_sel    = mux_sel_q;
    assign mem_wr     = mem_wr_q;
    assign ir_load    = ir_load_q;
    assign mdr_load   = mdr_load_q;
    assign exc_load   = exc_load_q;
    assign fetch_done = fetch_done_q;
    assign data_done  = data_done_q;
    assign exc_done   = exc_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: main instance at latency 2, plus latency 0 and 5
// instances exercised with a single fetch each.
module tb_mem_access_sequencer;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req, data_req, data_wr, data_src, exc_req;
    logic [1:0] exc_cause;
    logic [2:0] mux_sel;
    logic       mem_wr, ir_load, mdr_load, exc_load, fetch_done, data_done, exc_done, busy;

    logic       z_fetch_req, f_fetch_req;
    logic [2:0] z_mux_sel, f_mux_sel;
    logic       z_mem_wr, z_ir_load, z_mdr_load, z_exc_load, z_fetch_done, z_data_done, z_exc_done, z_busy;
    logic       f_mem_wr, f_ir_load, f_mdr_load, f_exc_load, f_fetch_done, f_data_done, f_exc_done, f_busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_sequencer #(.MEM_LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
        .data_wr(data_wr), .data_src(data_src), .exc_req(exc_req), .exc_cause(exc_cause),
        .mux_sel(mux_sel), .mem_wr(mem_wr), .ir_load(ir_load), .mdr_load(mdr_load),
        .exc_load(exc_load), .fetch_done(fetch_done), .data_done(data_done),
        .exc_done(exc_done), .busy(busy)
    );

    mem_access_sequencer #(.MEM_LATENCY(0), .CNT_W(4)) dut_lat0 (
        .clk(clk), .reset(reset), .fetch_req(z_fetch_req), .data_req(1'b0),
        .data_wr(1'b0), .data_src(1'b0), .exc_req(1'b0), .exc_cause(2'b00),
        .mux_sel(z_mux_sel), .mem_wr(z_mem_wr), .ir_load(z_ir_load), .mdr_load(z_mdr_load),
        .exc_load(z_exc_load), .fetch_done(z_fetch_done), .data_done(z_data_done),
        .exc_done(z_exc_done), .busy(z_busy)
    );

    mem_access_sequencer #(.MEM_LATENCY(5), .CNT_W(4)) dut_lat5 (
        .clk(clk), .reset(reset), .fetch_req(f_fetch_req), .data_req(1'b0),
        .data_wr(1'b0), .data_src(1'b0), .exc_req(1'b0), .exc_cause(2'b00),
        .mux_sel(f_mux_sel), .mem_wr(f_mem_wr), .ir_load(f_ir_load), .mdr_load(f_mdr_load),
        .exc_load(f_exc_load), .fetch_done(f_fetch_done), .data_done(f_data_done),
        .exc_done(f_exc_done), .busy(f_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Expected transaction: select, done vector {exc,data,fetch}, load vector {exc,mdr,ir}
    typedef struct {
        logic [2:0] sel;
        logic [2:0] done_v;
        logic [2:0] load_v;
        int         wr_cnt;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push(input logic [2:0] sel, input logic [2:0] dv,
                                 input logic [2:0] lv, input int wr, input int dc);
        exp_t e;
        e.sel = sel; e.done_v = dv; e.load_v = lv; e.wr_cnt = wr; e.done_cyc = dc;
        exp_q.push_back(e);
    endfunction

    // Transaction monitor: tracks each busy window and scores it at its done pulse
    bit         in_txn = 1'b0;
    bit         sel_moved;
    int         len, wr_seen;
    logic [2:0] sel0;
    exp_t       got;

    always @(negedge clk) begin
        if (reset) begin
            in_txn = 1'b0;
        end else if (busy) begin
            if (!in_txn) begin
                in_txn = 1'b1; len = 0; wr_seen = 0; sel0 = mux_sel; sel_moved = 1'b0;
            end
            len++;
            if (mux_sel !== sel0) sel_moved = 1'b1;
            if (mem_wr) wr_seen++;
            if (fetch_done | data_done | exc_done) begin
                in_txn = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    check("mux_sel", 32'(sel0), 32'(got.sel));
                    check("sel_stable", 32'(sel_moved), 32'd0);
                    check("done_vec", 32'({exc_done, data_done, fetch_done}), 32'(got.done_v));
                    check("load_vec", 32'({exc_load, mdr_load, ir_load}), 32'(got.load_v));
                    check("mem_wr_cycles", 32'(wr_seen), 32'(got.wr_cnt));
                    check("busy_len", 32'(len), 32'(LAT + 2));
                    check("done_cycle", 32'(cyc), 32'(got.done_cyc));
                end
            end else begin
                check("early_strobe", 32'({ir_load, mdr_load, exc_load}), 32'd0);
            end
        end else begin
            in_txn = 1'b0;
            check("idle_outputs", 32'({mux_sel, mem_wr, ir_load, mdr_load, exc_load,
                                       fetch_done, data_done, exc_done}), 32'd0);
        end
    end

    // Requester behaviour: each drops its req in the cycle its done pulse is seen
    task automatic serve(input int budget);
        int n;
        n = 0;
        while ((fetch_req | data_req | exc_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (exc_done)   exc_req   = 1'b0;
            if (data_done)  data_req  = 1'b0;
            if (fetch_done) fetch_req = 1'b0;
        end
        if (fetch_req | data_req | exc_req) begin
            check("serve_timeout", 32'd1, 32'd0);
            fetch_req = 1'b0; data_req = 1'b0; exc_req = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    int         c;
    int         z_done, f_done, z_len, f_len;
    logic [2:0] cause_sel [4];
    logic [1:0] cause;

    initial begin
        cause_sel[0] = 3'b100; cause_sel[1] = 3'b011; cause_sel[2] = 3'b010; cause_sel[3] = 3'b100;
        reset = 1'b1;
        fetch_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_src = 1'b0;
        exc_req = 1'b0; exc_cause = 2'b00; z_fetch_req = 1'b0; f_fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({busy, mux_sel, mem_wr, ir_load, mdr_load, exc_load,
                                  fetch_done, data_done, exc_done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain fetch from PC
        c = cyc; push(3'b000, 3'b001, 3'b001, 0, c + 2 + LAT);
        fetch_req = 1'b1; serve(40);

        // Store via RD, then load via ALUOut
        c = cyc; push(3'b101, 3'b010, 3'b000, 1, c + 2 + LAT);
        data_req = 1'b1; data_wr = 1'b1; data_src = 1'b1; serve(40);
        c = cyc; push(3'b001, 3'b010, 3'b010, 0, c + 2 + LAT);
        data_req = 1'b1; data_wr = 1'b0; data_src = 1'b0; serve(40);

        // All three together: exception, then data, then fetch, one IDLE cycle apart
        c = cyc;
        push(3'b011, 3'b100, 3'b100, 0, c + 2 + LAT);
        push(3'b101, 3'b010, 3'b010, 0, c + 5 + 2 * LAT);
        push(3'b000, 3'b001, 3'b001, 0, c + 8 + 3 * LAT);
        exc_cause = 2'b01; data_wr = 1'b0; data_src = 1'b1;
        exc_req = 1'b1; data_req = 1'b1; fetch_req = 1'b1;
        serve(80);

        // Every exception cause
        for (int i = 0; i < 4; i++) begin
            cause = 2'(i);
            c = cyc; push(cause_sel[i], 3'b100, 3'b100, 0, c + 2 + LAT);
            exc_cause = cause; exc_req = 1'b1; serve(40);
        end

        // Reset in the first WAIT cycle of a load, then the held req is served afresh
        c = cyc; data_wr = 1'b0; data_src = 1'b0; data_req = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", 32'({busy, mux_sel, mem_wr, mdr_load, data_done}), 32'd0);
        reset = 1'b0;
        c = cyc; push(3'b001, 3'b010, 3'b010, 0, c + 2 + LAT);
        serve(40);

        // Latency 0 and 5 builds
        c = cyc; z_done = -1; f_done = -1; z_len = 0; f_len = 0;
        z_fetch_req = 1'b1; f_fetch_req = 1'b1;
        for (int i = 0; i < 30 && (z_done < 0 || f_done < 0); i++) begin
            @(negedge clk);
            if (z_busy) z_len++;
            if (f_busy) f_len++;
            if (z_fetch_done) begin
                z_done = cyc; z_fetch_req = 1'b0;
                check("lat0_ir_load", 32'(z_ir_load), 32'd1);
            end
            if (f_fetch_done) begin
                f_done = cyc; f_fetch_req = 1'b0;
                check("lat5_ir_load", 32'(f_ir_load), 32'd1);
            end
        end
        z_fetch_req = 1'b0; f_fetch_req = 1'b0;
        check("lat0_done_cycle", 32'(z_done), 32'(c + 2));
        check("lat0_busy_len", 32'(z_len), 32'd2);
        check("lat5_done_cycle", 32'(f_done), 32'(c + 7));
        check("lat5_busy_len", 32'(f_len), 32'd7);
        @(negedge clk);
        check("lat0_idle", 32'({z_busy, z_mux_sel, z_mem_wr, z_ir_load, z_mdr_load, z_exc_load,
                                z_fetch_done, z_data_done, z_exc_done}), 32'd0);
        check("lat5_idle", 32'({f_busy, f_mux_sel, f_mem_wr, f_ir_load, f_mdr_load, f_exc_load,
                                f_fetch_done, f_data_done, f_exc_done}), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multicycle-CPU controller that owns the memory-address mux select and the memory write strobe.
- Arbitrates three requesters for the single memory port: instruction fetch (address from PC), data load/store (address from ALUOut or RD), and exception-vector fetch (fixed bytes 255/254/253).
- Sequences each access through address setup, a parameterised memory latency and a completion cycle.
- Issues load strobes for IR, MDR and the exception-vector register.

Parameters:
- MEM_LATENCY, 2, wait cycles between address setup and valid read data. Legal range 0..15.
- CNT_W, 4, width of the latency counter. Must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  instruction-fetch request (level, held until fetch_done)
- data_req  in  1  data-access request (level, held until data_done)
- data_wr  in  1  1 = store, 0 = load. Sampled at grant.
- data_src  in  1  0 = ALUOut address, 1 = RD address. Sampled at grant.
- exc_req  in  1  exception-vector fetch request (level, held until exc_done)
- exc_cause  in  2  00 invalid opcode, 01 overflow, 10 divide-by-zero, 11 reserved. Sampled at grant.
- mux_sel  out  3  address-mux select: 000 PC, 001 ALUOut, 010 const 255, 011 const 254, 100 const 253, 101 RD
- mem_wr  out  1  memory write enable
- ir_load  out  1  one-cycle IR load strobe
- mdr_load  out  1  one-cycle MDR load strobe
- exc_load  out  1  one-cycle vector-register load strobe
- fetch_done, data_done, exc_done  out  1 each  one-cycle completion pulses
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous; applies mid-transaction too): state IDLE, counter 0, latched fields 0, mux_sel 000, all strobes, done pulses and busy 0. An in-flight access is abandoned and no done pulse is issued.
- States: IDLE -> ADDR -> WAIT -> DONE -> IDLE. WAIT is skipped when MEM_LATENCY = 0.
- IDLE:
  - At each edge, sample requests. Priority is exc_req > data_req > fetch_req.
  - Latch the winner, data_wr, data_src and exc_cause; go to ADDR.
  - With no request, stay in IDLE; mux_sel = 000.
- ADDR (1 cycle):
  - mux_sel is driven from the latched winner. Exception cause mapping: 00 -> 100, 01 -> 011, 10 -> 010, 11 -> 100.
  - mem_wr = 1 in this cycle only, and only for a data store.
  - Counter is loaded with MEM_LATENCY.
- WAIT: counter decrements each cycle; go to DONE on the edge where counter = 1.
- DONE (1 cycle):
  - The winner's done pulse is asserted.
  - Load strobe: ir_load for a fetch, mdr_load for a data load, exc_load for an exception. No load strobe for a store.
- mux_sel is held constant from ADDR through DONE. The memory address must never glitch mid-access.
- Latency: a request sampled at edge t0 gives ADDR in cycle t0+1 and DONE in cycle t0+2+MEM_LATENCY (cycle t0+4 for the default).
- Handshake:
  - A requester must drop its req before the edge that ends the IDLE cycle following DONE. Otherwise the held req is a new request.
  - Minimum one IDLE cycle between transactions.
  - A req dropped mid-transaction does not abort the access.
  - Requests raised while busy are ignored until IDLE.
- Simultaneous requests: only the highest-priority request is served. The losers stay pending (they hold their req) and are served in later transactions in priority order.
- mem_wr never asserts outside ADDR. Any unused mux_sel encoding (110, 111) is unreachable.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - state enum (IDLE, ADDR, WAIT, DONE)
  - mux-select constants SEL_PC, SEL_ALUOUT, SEL_V255, SEL_V254, SEL_V253, SEL_RD
  - exception-cause codes
- Sub-module mem_req_arbiter: combinational fixed-priority encoder that takes the three reqs and produces a one-hot grant. The FSM and counter stay in the top module.

Test Plan:
- Reset then fetch_req=1: mux_sel=000 during ADDR, WAIT and DONE; ir_load and fetch_done pulse in cycle t0+4; busy high for exactly 4 cycles.
- data_req=1, data_wr=1, data_src=1: mux_sel=101; mem_wr=1 only in the ADDR cycle; data_done at t0+4; mdr_load stays 0.
- exc_req, fetch_req and data_req raised together with exc_cause=01: exception served first (mux_sel=011, exc_load at t0+4), then data_req, then fetch_req. Each transaction is separated by one IDLE cycle.
- Each exc_cause 00/10/11 yields mux_sel 100/010/100 respectively.
- reset asserted during WAIT of a load: next cycle IDLE, busy=0, mux_sel=000, no mdr_load or done pulse. A held data_req is then re-served from scratch.
- MEM_LATENCY=0 build, fetch: ADDR then DONE, fetch_done at t0+2. MEM_LATENCY=5 build: fetch_done at t0+7.
